// File: rtl/binary_subtractor_serial.sv
// Bit-serial unsigned subtractor: d = {borrow, (a - b) mod 2^W}, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for start; d holds the last completed result
// SHIFT | one difference bit per edge, W edges total
// DONE  | single cycle, d carries the new result, done pulses
module binary_subtractor_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   d,
    output logic         busy,
    output logic         done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic [W-1:0]  res_next;
    logic          br;
    logic          br_next;
    logic          diff_bit;
    logic [CW-1:0] cnt;
    logic          last_bit;

    // Full-subtractor cell on the current LSBs, plus the result register shifted one place
    always_comb begin
        diff_bit         = a_sh[0] ^ b_sh[0] ^ br;
        br_next          = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next         = res_sh >> 1;
        res_next[W-1]    = diff_bit;
        last_bit         = (cnt == CW'(W - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result update; d only changes on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        d <= {br_next, res_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_subtractor_serial.sv
// Directed bench for binary_subtractor_serial with W=4.
module tb_binary_subtractor_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   d;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    binary_subtractor_serial #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .d     (d),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Capture one operation, then wait (bounded) for done; checks latency, result, busy and pulse width.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W:0] exp_d);
        int n;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_d"}, 32'(d), 32'(exp_d));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_d_hold"}, 32'(d), 32'(exp_d));
    endtask

    logic [W-1:0] ops_a [3];
    logic [W-1:0] ops_b [3];
    logic [W:0]   ops_d [3];

    initial begin
        int n;
        int pulses;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_d", 32'(d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // basic operations
        do_op("op_1010_0101", 4'b1010, 4'b0101, 5'b00101);
        do_op("op_0100_1000", 4'b0100, 4'b1000, 5'b11100);
        do_op("op_1111_1111", 4'b1111, 4'b1111, 5'b00000);
        do_op("op_0000_0001", 4'b0000, 4'b0001, 5'b11111);

        // start re-pulsed during SHIFT and DONE is ignored
        @(negedge clk);
        a = 4'b1010; b = 4'b0101; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("ign_lat", 32'(n), 32'd4);
        check("ign_d", 32'(d), 32'b00101);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ign_no_extra_done", 32'(pulses), 32'd0);
        check("ign_d_hold", 32'(d), 32'b00101);

        // reset mid-operation aborts without done
        @(negedge clk);
        a = 4'b1100; b = 4'b0011; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_d", 32'(d), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_d_hold", 32'(d), 32'd0);
        do_op("op_0111_0010", 4'b0111, 4'b0010, 5'b00101);

        // start held high: captures at offsets 0, 6, 12; operands change right after each capture
        ops_a[0] = 4'd3;  ops_b[0] = 4'd9; ops_d[0] = 5'b11010;
        ops_a[1] = 4'd12; ops_b[1] = 4'd5; ops_d[1] = 5'b00111;
        ops_a[2] = 4'd15; ops_b[2] = 4'd1; ops_d[2] = 5'b01110;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                check($sformatf("b2b_done_k%0d", k), 32'(done), 32'((k % 6) == 5));
                check($sformatf("b2b_excl_k%0d", k), 32'(busy & done), 32'd0);
                if ((k % 6) == 5) begin
                    check($sformatf("b2b_d_op%0d", k / 6), 32'(d), 32'(ops_d[k / 6]));
                end
            end
            if (k <= 12) begin
                a     = ops_a[(k + 5) / 6];
                b     = ops_b[(k + 5) / 6];
                start = 1'b1;
            end else begin
                a     = 4'hF;
                b     = 4'hF;
                start = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
